// File: rtl/asip_mem_pkg.sv
// Shared constants and types for the vector memory arbiter.
// This covers the word/vector geometry, the FSM state type and the beat-index type.
package asip_mem_pkg;

  localparam int VEC_W       = 192;
  localparam int WORD_W      = 32;
  localparam int ADDR_W      = 15;
  localparam int VGA_RUN_MAX = 4;
  localparam int LANES       = VEC_W / WORD_W;
  localparam int BEAT_W      = $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } arb_state_e;

  typedef logic [BEAT_W-1:0] beat_idx_t;

  // Index of the final CPU beat: lane 5 for vectors, lane 0 for scalars.
  function automatic beat_idx_t last_beat(input logic vec);
    return vec ? beat_idx_t'(LANES - 1) : beat_idx_t'(0);
  endfunction

endpackage

// File: rtl/vec_lane_buffer.sv
// 192-bit lane register that the arbiter shares between two jobs.
// It assembles read data one word at a time and serializes write data one lane at a time.
module vec_lane_buffer
  import asip_mem_pkg::*;
#(
  parameter int V = VEC_W,
  parameter int S = WORD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_en,
  input  logic [V-1:0] load_data,
  input  logic         word_we,
  input  beat_idx_t    word_idx,
  input  logic [S-1:0] word_data,
  input  beat_idx_t    sel_idx,
  output logic [S-1:0] sel_word,
  output logic [V-1:0] lanes
);

  logic [V-1:0] lanes_q, lanes_d;

  // A whole-vector load wins over a single-word update.
  always_comb begin
    lanes_d = lanes_q;
    if (load_en) begin
      lanes_d = load_data;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (word_we && word_idx == beat_idx_t'(k)) begin
          lanes_d[k*S +: S] = word_data;
        end
      end
    end
  end

  always_comb begin
    sel_word = '0;
    for (int k = 0; k < LANES; k++) begin
      if (sel_idx == beat_idx_t'(k)) begin
        sel_word = lanes_q[k*S +: S];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lanes_q <= '0;
    end else begin
      lanes_q <= lanes_d;
    end
  end

  assign lanes = lanes_q;

endmodule

// File: rtl/vec_mem_arbiter.sv
// Shares the single-port data RAM between the pipeline memory stage and the VGA fetcher.
// Define ARB_STARVE_GUARD_EN to cap consecutive VGA beats while a CPU burst is pending.
module vec_mem_arbiter
  import asip_mem_pkg::*;
#(
  parameter int V           = VEC_W,
  parameter int S           = WORD_W,
  parameter int AW          = ADDR_W,
  parameter int MAX_VGA_RUN = VGA_RUN_MAX
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic          cpu_vec,
  input  logic [S-1:0]  cpu_addr,
  input  logic [V-1:0]  cpu_wdata,
  output logic [V-1:0]  cpu_rdata,
  output logic          cpu_done,
  output logic          cpu_stall,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic          vga_gnt,
  output logic [S-1:0]  vga_rdata,
  output logic          vga_valid,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [S-1:0]  ram_wdata,
  input  logic [S-1:0]  ram_rdata
);

  arb_state_e    state_q, state_d;
  logic          we_q, we_d;
  logic          vec_q, vec_d;
  logic [AW-1:0] base_q, base_d;
  beat_idx_t     beat_q, beat_d;
  logic          rd_pend_q, rd_pend_d;
  beat_idx_t     rd_idx_q, rd_idx_d;
  logic          vga_valid_q, vga_valid_d;
  logic [V-1:0]  rdata_q, rdata_d;

  logic          force_cpu;
  logic          vga_own;
  logic          cpu_beat;
  logic          buf_load;
  logic [V-1:0]  buf_load_data;
  logic [S-1:0]  lane_word;
  logic [V-1:0]  buf_lanes;
  logic [V-1:0]  read_vec;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^cpu_addr[S-1:AW];

`ifdef ARB_STARVE_GUARD_EN
  localparam int RUN_W = $clog2(MAX_VGA_RUN + 1);

  logic [RUN_W-1:0] run_q, run_d;

  // Count VGA beats stolen from a pending burst; any CPU beat or leaving BURST restarts the run.
  always_comb begin
    run_d = run_q;
    if (state_q != BURST || cpu_beat) begin
      run_d = '0;
    end else if (vga_own && run_q != RUN_W'(MAX_VGA_RUN)) begin
      run_d = run_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= '0;
    end else begin
      run_q <= run_d;
    end
  end

  assign force_cpu = (state_q == BURST) && (run_q == RUN_W'(MAX_VGA_RUN));
`else
  localparam int unused_run_limit = MAX_VGA_RUN;

  assign force_cpu = 1'b0;
`endif

  // Exactly one RAM owner per cycle, and nobody owns it while reset is asserted.
  assign vga_own  = vga_req & ~force_cpu & ~rst;
  assign cpu_beat = (state_q == BURST) & ~vga_own & ~rst;

  assign vga_gnt   = vga_own;
  assign ram_we    = cpu_beat & we_q;
  assign ram_wdata = (cpu_beat & we_q) ? lane_word : '0;

  always_comb begin
    ram_addr = '0;
    if (vga_own) begin
      ram_addr = vga_addr;
    end else if (cpu_beat) begin
      ram_addr = base_q + AW'(beat_q);
    end
  end

  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    vec_d         = vec_q;
    base_d        = base_q;
    beat_d        = beat_q;
    rd_pend_d     = cpu_beat & ~we_q;
    rd_idx_d      = beat_q;
    buf_load      = 1'b0;
    buf_load_data = '0;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          we_d          = cpu_we;
          vec_d         = cpu_vec;
          base_d        = cpu_addr[AW-1:0];
          beat_d        = '0;
          buf_load      = 1'b1;
          buf_load_data = cpu_we ? cpu_wdata : '0;
          state_d       = BURST;
        end
      end
      BURST: begin
        if (cpu_beat) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == last_beat(vec_q)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  vec_lane_buffer #(
    .V(V),
    .S(S)
  ) u_lanes (
    .clk       (clk),
    .rst       (rst),
    .load_en   (buf_load),
    .load_data (buf_load_data),
    .word_we   (rd_pend_q),
    .word_idx  (rd_idx_q),
    .word_data (ram_rdata),
    .sel_idx   (beat_q),
    .sel_word  (lane_word),
    .lanes     (buf_lanes)
  );

  // The last read word arrives during DONE, so it is spliced in here rather than waiting a cycle.
  always_comb begin
    read_vec = buf_lanes;
    for (int k = 0; k < LANES; k++) begin
      if (rd_pend_q && rd_idx_q == beat_idx_t'(k)) begin
        read_vec[k*S +: S] = ram_rdata;
      end
    end
  end

  assign rdata_d     = (state_q == DONE && !we_q) ? read_vec : rdata_q;
  assign vga_valid_d = vga_own;

  assign cpu_rdata = rdata_d;
  assign cpu_done  = (state_q == DONE);
  assign cpu_stall = cpu_req & ~cpu_done;
  assign vga_valid = vga_valid_q;
  assign vga_rdata = vga_valid_q ? ram_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      vec_q       <= 1'b0;
      base_q      <= '0;
      beat_q      <= '0;
      rd_pend_q   <= 1'b0;
      rd_idx_q    <= '0;
      vga_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      vec_q       <= vec_d;
      base_q      <= base_d;
      beat_q      <= beat_d;
      rd_pend_q   <= rd_pend_d;
      rd_idx_q    <= rd_idx_d;
      vga_valid_q <= vga_valid_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_vec_mem_arbiter.sv
// Testbench for vec_mem_arbiter: a word RAM model, a transaction-level reference model and directed scenarios.
// The guard scenario is selected by ARB_STARVE_GUARD_EN, matching the build of the design.
module tb_vec_mem_arbiter;

  logic           clk = 1'b0;
  logic           rst;
  logic           cpu_req;
  logic           cpu_we;
  logic           cpu_vec;
  logic [31:0]    cpu_addr;
  logic [191:0]   cpu_wdata;
  logic [191:0]   cpu_rdata;
  logic           cpu_done;
  logic           cpu_stall;
  logic           vga_req;
  logic [14:0]    vga_addr;
  logic           vga_gnt;
  logic [31:0]    vga_rdata;
  logic           vga_valid;
  logic [14:0]    ram_addr;
  logic           ram_we;
  logic [31:0]    ram_wdata;
  logic [31:0]    ram_rdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vec_mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_vec   (cpu_vec),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_done  (cpu_done),
    .cpu_stall (cpu_stall),
    .vga_req   (vga_req),
    .vga_addr  (vga_addr),
    .vga_gnt   (vga_gnt),
    .vga_rdata (vga_rdata),
    .vga_valid (vga_valid),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Unwritten words read back as a recognisable address-derived pattern.
  function automatic logic [31:0] pat(input logic [14:0] a);
    return 32'hC0DE0000 | {17'b0, a};
  endfunction

  logic [31:0] ram_mem [int];
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] ramRead(input logic [14:0] a);
    return ram_mem.exists(int'(a)) ? ram_mem[int'(a)] : pat(a);
  endfunction

  function automatic logic [31:0] refRead(input logic [14:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pat(a);
  endfunction

  always @(posedge clk) begin
    ram_rdata <= ramRead(ram_addr);
    if (ram_we) ram_mem[int'(ram_addr)] = ram_wdata;
  end

  task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level reference: one RAM owner per cycle, so a burst takes N+1 cycles plus every VGA grant in between.
  logic          req_active = 1'b0;
  int            start_cyc;
  int            stolen;
  int            last_done = 0;
  logic          m_we;
  logic          m_vec;
  logic [14:0]   m_addr;
  logic [191:0]  m_wdata;
  logic          prev_gnt = 1'b0;
  logic [14:0]   prev_vaddr;
  int            wr_addr_q[$];
  int            wr_cyc_q[$];

  always @(negedge clk) begin
    if (rst) begin
      if (req_active && m_we) begin
        for (int k = 0; k < cyc - start_cyc - 1 - stolen; k++) begin
          ref_mem[int'(m_addr + 15'(k))] = m_wdata[k*32 +: 32];
        end
      end
      req_active = 1'b0;
      prev_gnt   = 1'b0;
    end else begin
      checkOutput("stall", 192'(cpu_stall), 192'(cpu_req & ~cpu_done));
      checkOutput("vga_valid", 192'(vga_valid), 192'(prev_gnt));
      if (prev_gnt) checkOutput("vga_rdata", 192'(vga_rdata), 192'(refRead(prev_vaddr)));
      if (vga_gnt) checkOutput("gnt_without_req", 192'(vga_req), 192'(1));
      prev_gnt   = vga_gnt;
      prev_vaddr = vga_addr;
      if (ram_we) begin
        wr_addr_q.push_back(int'(ram_addr));
        wr_cyc_q.push_back(cyc);
      end
      if (cpu_req && !req_active && !cpu_done) begin
        req_active = 1'b1;
        start_cyc  = cyc;
        stolen     = 0;
        m_we       = cpu_we;
        m_vec      = cpu_vec;
        m_addr     = cpu_addr[14:0];
        m_wdata    = cpu_wdata;
      end else if (req_active && !cpu_done && vga_gnt) begin
        stolen++;
      end
      if (cpu_done) begin
        logic [191:0] exp_rd;
        int n;
        n = m_vec ? 6 : 1;
        checkOutput("done_without_req", 192'(req_active), 192'(1));
        checkOutput("latency", 192'(cyc - start_cyc), 192'(n + 1 + stolen));
        if (m_we) begin
          for (int k = 0; k < n; k++) begin
            ref_mem[int'(m_addr + 15'(k))] = m_wdata[k*32 +: 32];
            checkOutput("ram_word", 192'(ramRead(m_addr + 15'(k))), 192'(m_wdata[k*32 +: 32]));
          end
        end else begin
          exp_rd = '0;
          for (int k = 0; k < n; k++) exp_rd[k*32 +: 32] = refRead(m_addr + 15'(k));
          checkOutput("cpu_rdata", cpu_rdata, exp_rd);
        end
        req_active = 1'b0;
        last_done  = cyc;
      end
    end
  end

  // Present one CPU access and hold it until cpu_done, bounded by a cycle budget.
  task automatic applyStimulus(input logic we, input logic vec, input logic [31:0] addr,
                               input logic [191:0] wd, output int lat, output logic [191:0] rd);
    int  t;
    logic got;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_vec   = vec;
    cpu_addr  = addr;
    cpu_wdata = wd;
    t   = cyc;
    got = 1'b0;
    lat = -1;
    rd  = '0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (cpu_done) begin
        got = 1'b1;
        lat = cyc - t;
        rd  = cpu_rdata;
      end
    end
    if (!got) checkOutput("done_timeout", 192'(0), 192'(1));
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  initial begin
    int            lat;
    int            t0;
    int            drop;
    logic [191:0]  rd;
    logic [191:0]  vec_a;
    logic [191:0]  vec_b;
    logic [191:0]  vec_c;

    vec_a = {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    vec_b = {32'hB5B5B5B5, 32'hB4B4B4B4, 32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0};
    vec_c = {32'hC5, 32'hC4, 32'hC3, 32'hC2, 32'hC1, 32'hC0};

    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_vec = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vga_req = 1'b0; vga_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    checkOutput("reset_done", 192'(cpu_done), 192'(0));
    checkOutput("reset_valid", 192'(vga_valid), 192'(0));
    checkOutput("reset_cpu_rdata", cpu_rdata, 192'(0));
    checkOutput("reset_ram_addr", 192'(ram_addr), 192'(0));
    checkOutput("reset_ram_we", 192'(ram_we), 192'(0));
    @(posedge clk); #1;

    $display("[TB] scalar round trip");
    applyStimulus(1'b1, 1'b0, 32'h10, {160'b0, 32'hDEADBEEF}, lat, rd);
    checkOutput("scalar_wr_lat", 192'(lat), 192'(2));
    applyStimulus(1'b0, 1'b0, 32'h10, '0, lat, rd);
    checkOutput("scalar_rd_lat", 192'(lat), 192'(2));
    checkOutput("scalar_rd_data", rd, {160'b0, 32'hDEADBEEF});

    $display("[TB] vector write/read");
    wr_addr_q.delete(); wr_cyc_q.delete();
    t0 = cyc;
    applyStimulus(1'b1, 1'b1, 32'd100, vec_a, lat, rd);
    checkOutput("vec_wr_lat", 192'(lat), 192'(7));
    checkOutput("vec_wr_count", 192'(wr_addr_q.size()), 192'(6));
    for (int k = 0; k < 6 && k < wr_addr_q.size(); k++) begin
      checkOutput("vec_wr_addr", 192'(wr_addr_q[k]), 192'(100 + k));
      checkOutput("vec_wr_cycle", 192'(wr_cyc_q[k] - t0), 192'(k + 1));
    end
    applyStimulus(1'b0, 1'b1, 32'd100, '0, lat, rd);
    checkOutput("vec_rd_lat", 192'(lat), 192'(7));
    checkOutput("vec_rd_data", rd, vec_a);

    $display("[TB] back-to-back VGA reads");
    for (int i = 0; i < 4; i++) begin
      vga_req  = 1'b1;
      vga_addr = 15'(500 + i);
      @(negedge clk);
      checkOutput("vga_gnt_idle", 192'(vga_gnt), 192'(1));
      if (i == 1) checkOutput("vga_first_word", 192'(vga_rdata), 192'(32'hC0DE01F4));
      @(posedge clk); #1;
    end
    vga_req = 1'b0;
    @(negedge clk);
    checkOutput("vga_last_valid", 192'(vga_valid), 192'(1));
    checkOutput("vga_last_word", 192'(vga_rdata), 192'(32'hC0DE01F7));
    @(posedge clk); #1;

`ifdef ARB_STARVE_GUARD_EN
    $display("[TB] guard on, continuous VGA");
    fork
      applyStimulus(1'b0, 1'b1, 32'd100, '0, lat, rd);
      begin
        vga_req = 1'b1;
        for (int k = 0; k < 32; k++) begin
          vga_addr = 15'(1000 + k);
          @(negedge clk);
          checkOutput("guard_gnt", 192'(vga_gnt), 192'((k > 0 && k <= 30 && k % 5 == 0) ? 0 : 1));
          @(posedge clk); #1;
        end
        vga_req = 1'b0;
      end
    join
    checkOutput("guard_lat", 192'(lat), 192'(31));
    checkOutput("guard_rd_data", rd, vec_a);
`else
    $display("[TB] guard off, continuous VGA");
    fork
      applyStimulus(1'b0, 1'b1, 32'd100, '0, lat, rd);
      begin
        vga_req = 1'b1;
        for (int k = 0; k < 20; k++) begin
          vga_addr = 15'(1000 + k);
          @(negedge clk);
          checkOutput("starve_stall", 192'(cpu_stall), 192'(1));
          @(posedge clk); #1;
        end
        vga_req = 1'b0;
        drop = cyc;
      end
    join
    checkOutput("drain_done_cycle", 192'(last_done - drop), 192'(6));
    checkOutput("starve_rd_data", rd, vec_a);
`endif
    @(posedge clk); #1;

    $display("[TB] reset mid-burst");
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_vec = 1'b1; cpu_addr = 32'd300; cpu_wdata = vec_b;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_done", 192'(cpu_done), 192'(0));
    checkOutput("rst_stall", 192'(cpu_stall), 192'(0));
    checkOutput("rst_gnt", 192'(vga_gnt), 192'(0));
    checkOutput("rst_valid", 192'(vga_valid), 192'(0));
    checkOutput("rst_ram_we", 192'(ram_we), 192'(0));
    checkOutput("rst_cpu_rdata", cpu_rdata, 192'(0));
    checkOutput("rst_vga_rdata", 192'(vga_rdata), 192'(0));
    checkOutput("rst_ram_addr", 192'(ram_addr), 192'(0));
    checkOutput("rst_kept_0", 192'(ramRead(15'd300)), 192'(32'hB0B0B0B0));
    checkOutput("rst_kept_2", 192'(ramRead(15'd302)), 192'(32'hB2B2B2B2));
    checkOutput("rst_untouched_3", 192'(ramRead(15'd303)), 192'(32'hC0DE012F));
    checkOutput("rst_untouched_5", 192'(ramRead(15'd305)), 192'(32'hC0DE0131));
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b1, 32'd300, '0, lat, rd);
    checkOutput("rst_readback", rd, {32'hC0DE0131, 32'hC0DE0130, 32'hC0DE012F, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0});

    $display("[TB] address wrap");
    wr_addr_q.delete(); wr_cyc_q.delete();
    applyStimulus(1'b1, 1'b1, 32'd32766, vec_c, lat, rd);
    checkOutput("wrap_count", 192'(wr_addr_q.size()), 192'(6));
    for (int k = 0; k < 6 && k < wr_addr_q.size(); k++) begin
      checkOutput("wrap_addr", 192'(wr_addr_q[k]), 192'((32766 + k) % 32768));
    end
    checkOutput("wrap_word_0", 192'(ramRead(15'd0)), 192'(32'hC2));

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got running expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
